// File: rtl/tmr0_if.sv
// Timer0 bus bundle between the CPU-side logic and the TMR0 count stage.
//   tick_in  : divided tick from the prescaler (asynchronous to clk)
//   wr_en    : CPU write strobe for TMR0, with wr_data as the value to load
//   t0if_clr : CPU clear of the overflow flag
//   t0ie/gie : timer0 and global interrupt enables
//   tmr0     : current count
//   t0if     : sticky overflow flag
//   ovf      : one-cycle overflow pulse
//   irq      : timer0 interrupt request
// master = CPU / prescaler side, slave = count stage.
interface tmr0_if #(
    parameter int WIDTH = 8
);
    logic             tick_in;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             t0if_clr;
    logic             t0ie;
    logic             gie;
    logic [WIDTH-1:0] tmr0;
    logic             t0if;
    logic             ovf;
    logic             irq;

    modport master (
        output tick_in, wr_en, wr_data, t0if_clr, t0ie, gie,
        input  tmr0, t0if, ovf, irq
    );

    modport slave (
        input  tick_in, wr_en, wr_data, t0if_clr, t0ie, gie,
        output tmr0, t0if, ovf, irq
    );
endinterface

// File: rtl/tmr0_counter.sv
// Timer0 count register stage. Synchronises the prescaler tick, edge-detects
// it and increments TMR0 on each rising edge. CPU writes load TMR0 and open a
// short window during which increments are dropped. A counted wrap FF->00
// pulses ovf and sets the sticky t0if flag; irq = t0if & t0ie & gie.
//   clk : system clock (rising edge)
//   rst : synchronous, active-high reset
//   bus : tmr0_if slave port (tick, CPU write/clear, enables, count and flags)
module tmr0_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,   // >= 2
    parameter int WR_INHIBIT  = 2    // >= 1
) (
    input  logic  clk,
    input  logic  rst,
    tmr0_if.slave bus
);
    localparam int ICW = (WR_INHIBIT < 1) ? 1 : $clog2(WR_INHIBIT + 1);

    typedef enum logic {IDLE, INHIB} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   edge_q;
    logic                   s;
    logic                   inc;
    logic                   inc_ok;
    logic                   wrap;
    logic [ICW-1:0]         ic;
    state_t                 state;

    assign s      = sync[SYNC_STAGES-1];
    assign inc    = s & ~edge_q;
    // state==IDLE tracks ic==0; a write in the same cycle also blocks the inc
    assign inc_ok = inc & (state == IDLE) & ~bus.wr_en;
    assign wrap   = inc_ok & (&bus.tmr0);

    assign bus.irq = bus.t0if & bus.t0ie & bus.gie;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            edge_q   <= 1'b0;
            ic       <= '0;
            state    <= IDLE;
            bus.tmr0 <= '0;
            bus.t0if <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], bus.tick_in};
            edge_q <= s;

            // inhibit window: reloads on every write, drains one per cycle
            if (bus.wr_en) begin
                ic    <= ICW'(WR_INHIBIT);
                state <= INHIB;
            end else if (ic != '0) begin
                ic <= ic - ICW'(1);
                if (ic == ICW'(1))
                    state <= IDLE;
            end

            // write wins over a coincident increment, which is discarded
            if (bus.wr_en)
                bus.tmr0 <= bus.wr_data;
            else if (inc_ok)
                bus.tmr0 <= bus.tmr0 + WIDTH'(1);

            bus.ovf <= wrap;

            // set beats clear when both land in the same cycle
            if (wrap)
                bus.t0if <= 1'b1;
            else if (bus.t0if_clr)
                bus.t0if <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tmr0_counter.sv
module tb_tmr0_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   ovf_cnt = 0;
    int   ovf_base;

    tmr0_if #(.WIDTH(8)) bus ();

    tmr0_counter #(.WIDTH(8), .SYNC_STAGES(2), .WR_INHIBIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // counts cycles with ovf high, sampled mid-cycle
    always @(negedge clk) if (bus.ovf === 1'b1) ovf_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        bus.wr_en = 1'b1; bus.wr_data = v;
        cyc(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse();
        bus.tick_in = 1'b1; cyc(4);
        bus.tick_in = 1'b0; cyc(4);
    endtask

    initial begin
        bus.tick_in = 0; bus.wr_en = 0; bus.wr_data = 0;
        bus.t0if_clr = 0; bus.t0ie = 0; bus.gie = 0;

        // 1: reset then 10 ticks
        cyc(2);
        chk("rst_tmr0", 32'(bus.tmr0), 32'h0);
        chk("rst_t0if", 32'(bus.t0if), 32'h0);
        chk("rst_ovf",  32'(bus.ovf),  32'h0);
        chk("rst_irq",  32'(bus.irq),  32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) pulse();
        chk("t1_tmr0", 32'(bus.tmr0), 32'd10);
        chk("t1_t0if", 32'(bus.t0if), 32'h0);
        chk("t1_ovf_never", 32'(ovf_cnt), 32'd0);

        // 2: wrap from FD
        wr(8'hFD);
        chk("t2_wr", 32'(bus.tmr0), 32'hFD);
        cyc(3);
        pulse(); chk("t2_fe", 32'(bus.tmr0), 32'hFE);
        pulse(); chk("t2_ff", 32'(bus.tmr0), 32'hFF);
        chk("t2_t0if_pre", 32'(bus.t0if), 32'h0);
        ovf_base = ovf_cnt;
        pulse(); chk("t2_00", 32'(bus.tmr0), 32'h00);
        chk("t2_ovf_once", 32'(ovf_cnt - ovf_base), 32'd1);
        chk("t2_t0if", 32'(bus.t0if), 32'h1);
        chk("t2_irq_00", 32'(bus.irq), 32'h0);
        bus.t0ie = 1; #1;
        chk("t2_irq_10", 32'(bus.irq), 32'h0);
        bus.t0ie = 0; bus.gie = 1; #1;
        chk("t2_irq_01", 32'(bus.irq), 32'h0);
        bus.t0ie = 1; #1;
        chk("t2_irq_11", 32'(bus.irq), 32'h1);
        bus.t0if_clr = 1; cyc(1); bus.t0if_clr = 0;
        chk("t2_clr", 32'(bus.t0if), 32'h0);
        chk("t2_clr_irq", 32'(bus.irq), 32'h0);

        // 3: tick lands in the inhibit window after writing 0x40
        bus.wr_en = 1; bus.wr_data = 8'h40; bus.tick_in = 1;
        cyc(1); bus.wr_en = 0;
        cyc(3); bus.tick_in = 0; cyc(4);
        chk("t3_inhib", 32'(bus.tmr0), 32'h40);
        pulse();
        chk("t3_next", 32'(bus.tmr0), 32'h41);

        // 4: write coincident with inc at 0x10
        wr(8'h10); cyc(3);
        bus.tick_in = 1; cyc(2);
        bus.wr_en = 1; bus.wr_data = 8'h80;
        cyc(1); bus.wr_en = 0;
        chk("t4_wr_wins", 32'(bus.tmr0), 32'h80);
        cyc(2); bus.tick_in = 0; cyc(4);
        chk("t4_no_defer", 32'(bus.tmr0), 32'h80);

        // 5: clear coincident with wrap, then clear next cycle
        wr(8'hFF); cyc(3);
        chk("t5_ff_noflag", 32'(bus.t0if), 32'h0);
        bus.tick_in = 1; cyc(2);
        bus.t0if_clr = 1; cyc(1);
        chk("t5_wrap", 32'(bus.tmr0), 32'h00);
        chk("t5_set_wins", 32'(bus.t0if), 32'h1);
        cyc(1); bus.t0if_clr = 0;
        chk("t5_cleared", 32'(bus.t0if), 32'h0);
        chk("t5_irq", 32'(bus.irq), 32'h0);
        cyc(1); bus.tick_in = 0; cyc(5);

        // 6: reset mid-inhibit with a tick pending
        wr(8'hFF); cyc(3); pulse();
        chk("t6_t0if_set", 32'(bus.t0if), 32'h1);
        bus.wr_en = 1; bus.wr_data = 8'h55; bus.tick_in = 1;
        cyc(1); bus.wr_en = 0;
        chk("t6_55", 32'(bus.tmr0), 32'h55);
        rst = 1; bus.tick_in = 0;
        cyc(1); rst = 0;
        chk("t6_rst_tmr0", 32'(bus.tmr0), 32'h0);
        chk("t6_rst_t0if", 32'(bus.t0if), 32'h0);
        chk("t6_rst_irq",  32'(bus.irq),  32'h0);
        cyc(5);
        chk("t6_dropped", 32'(bus.tmr0), 32'h0);
        pulse();
        chk("t6_first", 32'(bus.tmr0), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
